pipe_datapath: RTL

- Two-stage, parametrised integer datapath: register file, operand select (register or immediate) and multi-function ALU.
- Stage 1 (RD) reads operands; stage 2 (EX) executes and writes back.
- Adds a valid/ready input handshake, EX-to-RD forwarding and an iterative multi-cycle MUL that stalls the front end.
- Sits between the decoder/control unit and PC logic; `eq` feeds branch resolution, `a0` feeds the top-level output.

---
 rtl/pipe_datapath_pkg.sv | 38 +++
 rtl/pipe_datapath_if.sv | 35 +++
 rtl/pipe_datapath_mul.sv | 60 ++++++
 rtl/pipe_datapath.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pipe_datapath_pkg.sv
// pipe_datapath_pkg: shared types for the two-stage datapath.
//   alu_op_e    : 4-bit ALU operation encodings driven on alu_ctrl.
//   mul_state_e : iterative multiplier FSM states.
//   ex_stage_t  : contents of the RD->EX pipeline register.
// The EX struct is sized by PD_A_WIDTH/PD_D_WIDTH; pipe_datapath defaults its
// A_WIDTH/D_WIDTH parameters to these values and must be built with them.
package pipe_datapath_pkg;

  localparam int PD_A_WIDTH = 5;
  localparam int PD_D_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic [PD_D_WIDTH-1:0] op1;
    logic [PD_D_WIDTH-1:0] op2;
    logic [PD_A_WIDTH-1:0] rd;
    logic                  reg_write;
    logic [3:0]            alu_ctrl;
    logic                  valid;
  } ex_stage_t;

endpackage

// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: instruction handshake and retire bus of pipe_datapath.
//   master : decoder/control side (drives the instruction, observes results).
//   slave  : datapath side.
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on datapath state, never on
// in_valid. out_valid is a one-cycle pulse with no back-pressure; result/eq
// are meaningful while it is high and hold their last value otherwise.
interface pipe_datapath_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] rs1;
  logic [A_WIDTH-1:0] rs2;
  logic [A_WIDTH-1:0] rd;
  logic               reg_write;
  logic               alu_src;
  logic [3:0]         alu_ctrl;
  logic [D_WIDTH-1:0] imm_op;
  logic               out_valid;
  logic [D_WIDTH-1:0] result;
  logic               eq;
  logic [D_WIDTH-1:0] a0;

  modport master (
    output in_valid, rs1, rs2, rd, reg_write, alu_src, alu_ctrl, imm_op,
    input  in_ready, out_valid, result, eq, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, reg_write, alu_src, alu_ctrl, imm_op,
    output in_ready, out_valid, result, eq, a0
  );
endinterface

// File: rtl/pipe_datapath_mul.sv
// iter_mul: iterative shift-add multiplier, one multiplier bit per cycle.
//   start   : load op1/op2 and enter BUSY (only sampled when idle or done).
//   busy    : FSM state bit (1 = MUL_BUSY); doubles as the debug state view.
//   done    : completion cycle (BUSY with count 0); product is valid now.
//   product : low D_WIDTH bits of op1*op2, combinational in the done cycle.
// BUSY lasts D_WIDTH cycles: count runs D_WIDTH-1 .. 0.
module iter_mul
  import pipe_datapath_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] op1,
  input  logic [D_WIDTH-1:0] op2,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] product
);
  localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [0:0] ST_IDLE = MUL_IDLE;
  localparam logic [0:0] ST_BUSY = MUL_BUSY;

  logic [0:0]         state;
  logic [CW-1:0]      count;
  logic [D_WIDTH-1:0] mcand;
  logic [D_WIDTH-1:0] mplier;
  logic [D_WIDTH-1:0] acc;
  logic [D_WIDTH-1:0] partial;

  // The last bit is folded in combinationally so the product is ready in the
  // completion cycle rather than one cycle later.
  assign partial = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state == ST_BUSY);
  assign done    = busy && (count == '0);
  assign product = partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      state  <= ST_BUSY;
      count  <= CW'(D_WIDTH - 1);
      mcand  <= op1;
      mplier <= op2;
      acc    <= '0;
    end else if (busy) begin
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (count == '0) state <= ST_IDLE;
    end
  end
endmodule

// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage integer datapath (RD: register read / operand
// select, EX: ALU or iterative MUL, writeback and retire).
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : pipe_datapath_if.slave (instruction handshake, result, eq, a0).
// EX results are forwarded to the RD stage in the cycle they complete, so
// dependent back-to-back instructions never stall. A MUL holds EX for
// D_WIDTH cycles and blocks new accepts until its completion cycle.
module pipe_datapath
  import pipe_datapath_pkg::*;
#(
  parameter int A_WIDTH = PD_A_WIDTH,
  parameter int D_WIDTH = PD_D_WIDTH,
  parameter int A0_IDX  = 10
) (
  input logic clk,
  input logic rst,
  pipe_datapath_if.slave bus
);
  localparam int NREG = 2 ** A_WIDTH;
  localparam int SW   = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  logic [D_WIDTH-1:0] regs [NREG];
  ex_stage_t          ex;

  logic               accept;
  logic               ex_is_mul;
  logic               ex_done;
  logic               fwd_ok;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [D_WIDTH-1:0] mul_product;
  logic [D_WIDTH-1:0] op1_rd;
  logic [D_WIDTH-1:0] op2_rd;
  logic [D_WIDTH-1:0] alu_res;
  logic [D_WIDTH-1:0] ex_result;
  logic               out_valid_q;
  logic [D_WIDTH-1:0] result_q;
  logic               eq_q;

  // Stall only while a MUL is mid-flight; its completion cycle can accept.
  assign bus.in_ready = !(ex.valid && mul_busy && !mul_done);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.alu_ctrl == ALU_MUL);

  assign ex_is_mul = (ex.alu_ctrl == ALU_MUL);
  assign ex_done   = ex.valid && (ex_is_mul ? mul_done : 1'b1);
  assign ex_result = ex_is_mul ? mul_product : alu_res;

  // Forward only a result that is actually being written back this edge.
  assign fwd_ok = ex_done && ex.reg_write && (ex.rd != '0);

  assign op1_rd = (fwd_ok && bus.rs1 == ex.rd) ? ex_result : regs[bus.rs1];
  assign op2_rd = bus.alu_src ? bus.imm_op :
                  ((fwd_ok && bus.rs2 == ex.rd) ? ex_result : regs[bus.rs2]);

  always_comb begin
    alu_res = '0;
    case (ex.alu_ctrl)
      ALU_ADD: alu_res = ex.op1 + ex.op2;
      ALU_SUB: alu_res = ex.op1 - ex.op2;
      ALU_AND: alu_res = ex.op1 & ex.op2;
      ALU_OR:  alu_res = ex.op1 | ex.op2;
      ALU_XOR: alu_res = ex.op1 ^ ex.op2;
      ALU_SLT: alu_res = D_WIDTH'($signed(ex.op1) < $signed(ex.op2));
      ALU_SLL: alu_res = ex.op1 << ex.op2[SW-1:0];
      ALU_SRL: alu_res = ex.op1 >> ex.op2[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  iter_mul #(.D_WIDTH(D_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op1     (op1_rd),
    .op2     (op2_rd),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex <= '0;
    end else if (accept) begin
      ex <= '{op1: op1_rd, op2: op2_rd, rd: bus.rd, reg_write: bus.reg_write,
              alu_ctrl: bus.alu_ctrl, valid: 1'b1};
    end else if (ex_done) begin
      ex.valid <= 1'b0;
    end
  end

  // Register 0 is never written, so reads of it return the reset value 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (fwd_ok) begin
      regs[ex.rd] <= ex_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      eq_q        <= 1'b0;
    end else begin
      out_valid_q <= ex_done;
      if (ex_done) begin
        result_q <= ex_result;
        eq_q     <= (ex.op1 == ex.op2);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.eq        = eq_q;
  assign bus.a0        = regs[A_WIDTH'(A0_IDX)];
endmodule
